fetch_unit: RTL and testbench

Instruction-fetch stage of the RISC-V pipeline. Owns the program counter, drives the word address into the combinational instruction memory, and captures the returned instruction with its PC into the IF/ID pipeline register consumed by decode. It handles stall, flush, control-flow redirect from execute, and a halt on EBREAK.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/if_id_register.sv | 42 ++++
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants, fetch FSM encoding and IF/ID control type.
// Imported by the fetch stage and its pipeline register.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HALT = 1'b1;

    typedef enum logic [1:0] {
        IFID_LOAD,
        IFID_HOLD,
        IFID_BUBBLE
    } ifid_ctrl_t;

    // Instruction fetch is word-granular, so redirect targets drop bits [1:0].
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: loads a fetched instruction, holds it, or
// replaces it with a bubble while keeping the last PC/link values.
module if_id_register
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  ifid_ctrl_t  ctrl,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] pc4_in,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        valid
);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr <= NOP_INSTR;
            pc    <= 32'h0;
            pc4   <= 32'h0;
            valid <= 1'b0;
        end else begin
            case (ctrl)
                IFID_LOAD: begin
                    instr <= instr_in;
                    pc    <= pc_in;
                    pc4   <= pc4_in;
                    valid <= 1'b1;
                end
                IFID_BUBBLE: begin
                    instr <= NOP_INSTR;
                    valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address,
// and steers the IF/ID register through stall, flush, redirect and EBREAK halt.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        STALL_IF,
    input  logic        FLUSH_IF,
    input  logic        REDIRECT_EX,
    input  logic [31:0] TARGET_EX,
    output logic [31:0] A_IM,
    input  logic [31:0] RD_IM,
    output logic [31:0] INSTR_ID,
    output logic [31:0] PC_ID,
    output logic [31:0] PC4_ID,
    output logic        VALID_ID,
    output logic        HALTED,
    output logic        MISALIGN
);

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [0:0]  state;
    logic [0:0]  state_next;
    logic        misalign_q;
    logic        ebreak_hit;
    ifid_ctrl_t  ifid_ctrl;

    assign pc_plus4 = pc + 32'd4;

    // EBREAK only counts when it actually lands in IF/ID as a real instruction.
    assign ebreak_hit = (state == RUN) && !REDIRECT_EX && !FLUSH_IF && !STALL_IF &&
                        (RD_IM == EBREAK_INSTR);

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        pc_next    = pc_plus4;
        state_next = state;
        ifid_ctrl  = IFID_LOAD;

        if (REDIRECT_EX) begin
            pc_next    = word_align(TARGET_EX);
            state_next = RUN;
        end else if (STALL_IF || (state == HALT) || ebreak_hit) begin
            pc_next = pc;
        end

        if (ebreak_hit) begin
            state_next = HALT;
        end

        if (REDIRECT_EX || FLUSH_IF) begin
            ifid_ctrl = IFID_BUBBLE;
        end else if (STALL_IF) begin
            ifid_ctrl = IFID_HOLD;
        end else if (state == HALT) begin
            ifid_ctrl = IFID_BUBBLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            state      <= RUN;
            misalign_q <= 1'b0;
        end else begin
            pc         <= pc_next;
            state      <= state_next;
            misalign_q <= REDIRECT_EX && (TARGET_EX[1:0] != 2'b00);
        end
    end

    if_id_register u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .ctrl     (ifid_ctrl),
        .instr_in (RD_IM),
        .pc_in    (pc),
        .pc4_in   (pc_plus4),
        .instr    (INSTR_ID),
        .pc       (PC_ID),
        .pc4      (PC4_ID),
        .valid    (VALID_ID)
    );

    // The memory must see the reset vector even before the first reset edge.
    assign A_IM     = rst_n ? pc : RESET_PC;
    assign HALTED   = (state == HALT);
    assign MISALIGN = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a cycle-level behavioural model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_if;
    logic        flush_if;
    logic        redirect_ex;
    logic [31:0] target_ex;
    logic [31:0] a_im;
    logic [31:0] rd_im;
    logic [31:0] instr_id;
    logic [31:0] pc_id;
    logic [31:0] pc4_id;
    logic        valid_id;
    logic        halted;
    logic        misalign;

    logic [31:0] mem [64];
    int vectors = 0;
    int miscompares = 0;
    logic check_en = 1'b0;

    // Behavioural view of the stage, as observed after each edge.
    logic [31:0] m_pc, m_instr, m_pcid, m_pc4;
    logic        m_valid, m_halted, m_mis;

    always #5 clk = ~clk;

    assign rd_im = mem[a_im[7:2]];

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .STALL_IF    (stall_if),
        .FLUSH_IF    (flush_if),
        .REDIRECT_EX (redirect_ex),
        .TARGET_EX   (target_ex),
        .A_IM        (a_im),
        .RD_IM       (rd_im),
        .INSTR_ID    (instr_id),
        .PC_ID       (pc_id),
        .PC4_ID      (pc4_id),
        .VALID_ID    (valid_id),
        .HALTED      (halted),
        .MISALIGN    (misalign)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        logic [31:0] word;
        logic [31:0] n_pc, n_instr, n_pcid, n_pc4;
        logic        n_valid, n_halted;
        word     = mem[m_pc[7:2]];
        n_pc     = m_pc;
        n_instr  = m_instr;
        n_pcid   = m_pcid;
        n_pc4    = m_pc4;
        n_valid  = m_valid;
        n_halted = m_halted;
        if (!rst_n) begin
            n_pc = RESET_PC; n_instr = NOP; n_pcid = 0; n_pc4 = 0;
            n_valid = 1'b0; n_halted = 1'b0;
        end else if (redirect_ex) begin
            n_pc = target_ex & ~32'd3;
            n_halted = 1'b0;
            n_instr = NOP; n_valid = 1'b0;
        end else begin
            if (flush_if) begin
                n_instr = NOP; n_valid = 1'b0;
            end else if (stall_if) begin
                // everything holds
            end else if (m_halted) begin
                n_instr = NOP; n_valid = 1'b0;
            end else begin
                n_instr = word; n_pcid = m_pc; n_pc4 = m_pc + 32'd4; n_valid = 1'b1;
                if (word == EBREAK) n_halted = 1'b1;
            end
            if (!stall_if && !m_halted && !(!flush_if && word == EBREAK))
                n_pc = m_pc + 32'd4;
        end
        m_pc     <= n_pc;
        m_instr  <= n_instr;
        m_pcid   <= n_pcid;
        m_pc4    <= n_pc4;
        m_valid  <= n_valid;
        m_halted <= n_halted;
        m_mis    <= rst_n && redirect_ex && (target_ex[1:0] != 2'b00);
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("a_im",     a_im,     rst_n ? m_pc : RESET_PC);
            check("instr_id", instr_id, m_instr);
            check("pc_id",    pc_id,    m_pcid);
            check("pc4_id",   pc4_id,   m_pc4);
            check("valid_id", {31'b0, valid_id}, {31'b0, m_valid});
            check("halted",   {31'b0, halted},   {31'b0, m_halted});
            check("misalign", {31'b0, misalign}, {31'b0, m_mis});
        end
    end

    // Apply one cycle of inputs; returns just after the following falling edge.
    task automatic step(input logic r, input logic s, input logic f,
                        input logic rd, input logic [31:0] t);
        rst_n = r; stall_if = s; flush_if = f; redirect_ex = rd; target_ex = t;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = (32'(i) << 20) | 32'h0000_0093;
        rst_n = 1'b0; stall_if = 1'b0; flush_if = 1'b0; redirect_ex = 1'b0; target_ex = 32'h0;
        @(posedge clk);
        check_en = 1'b1;
        @(negedge clk);
        #1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("rst_instr", instr_id, 32'h0000_0013);
        check("rst_valid", {31'b0, valid_id}, 32'h0);
        check("rst_a_im", a_im, 32'h0);

        // Sequential fetch from reset vector
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("first_instr", instr_id, 32'h0000_0093);
        check("first_pc4", pc4_id, 32'h4);
        check("first_a_im", a_im, 32'h4);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // Stall three cycles at PC=8
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("stall_a_im", a_im, 32'h8);
        check("stall_pc_id", pc_id, 32'h4);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("resume_a_im", a_im, 32'hC);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // Redirect to 0x40 from PC=0x10
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h40);
        check("redir_a_im", a_im, 32'h40);
        check("redir_bubble", instr_id, 32'h0000_0013);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("redir_pc_id", pc_id, 32'h40);
        check("redir_instr", instr_id, 32'h0100_0093);

        // Redirect beats stall; misaligned target
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h22);
        check("mis_a_im", a_im, 32'h20);
        check("mis_pulse", {31'b0, misalign}, 32'h1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("mis_drop", {31'b0, misalign}, 32'h0);

        // Flush alone advances PC; flush with stall holds PC
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        check("flush_a_im", a_im, 32'h28);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("flush_stall_a_im", a_im, 32'h28);

        // PC wrap at top of address space
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap_pc4", pc4_id, 32'h0);
        check("wrap_a_im", a_im, 32'h0);

        // EBREAK at 0x0C halts fetch
        mem[3] = EBREAK;
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("ebreak_instr", instr_id, 32'h0010_0073);
        check("ebreak_halted", {31'b0, halted}, 32'h1);
        check("ebreak_a_im", a_im, 32'hC);
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("halt_bubble", {31'b0, valid_id}, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        check("unhalt", {31'b0, halted}, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("unhalt_pc_id", pc_id, 32'h0);

        // Halt again, then reset with flush high
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'hC);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0; flush_if = 1'b1;
        #1;
        check("reset_comb_a_im", a_im, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        check("reset_halted", {31'b0, halted}, 32'h0);
        check("reset_pc_id", pc_id, 32'h0);
        check("reset_instr", instr_id, 32'h0000_0013);
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
